inst_queue: RTL

Instruction queue feeding the systolic-array control unit. It buffers 16-bit instructions written by the host-side AXI-Lite register path and presents the head entry to the control unit's `instruction` input. The entry is consumed on every clock where the control unit raises `flag`. When the queue is empty or stopped, it substitutes IDLE_INST (all-zero opcode) so the control unit keeps cycling in IDLE.

---
 rtl/sa_share_pkg.sv | 24 ++
 rtl/inst_fifo_mem.sv | 68 ++++++
 rtl/inst_queue.sv | 110 +++++++++++
 3 files changed

// File: rtl/sa_share_pkg.sv
// Shared systolic-array definitions: instruction width, opcode field, idle
// instruction and the instruction-queue state encoding.
package sa_share;

    localparam int INST_BITS = 16;

    // Opcode occupies the top nibble of each instruction word.
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int OPC_W  = OPC_HI - OPC_LO + 1;

    localparam logic [INST_BITS-1:0] IDLE_INST = '0;

    typedef enum logic [1:0] {
        Q_STOP  = 2'd0,
        Q_RUN   = 2'd1,
        Q_FLUSH = 2'd2
    } q_state_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INST_BITS-1:0] inst);
        return inst[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/inst_fifo_mem.sv
// Register-array FIFO with show-ahead read, separate occupancy counter and a
// synchronous clear that overrides push/pop.
module inst_fifo_mem #(
    parameter  int W     = 16,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);
    import sa_share::*;

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;

    // Storage is not reset: count gates every read, so stale words never escape.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({push_i, pop_i})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/inst_queue.sv
// Instruction queue in front of the systolic-array control unit: STOP/RUN/FLUSH
// control, IDLE substitution and optional statistics (INST_QUEUE_STATS_EN).
module inst_queue #(
    parameter  int INST_BITS = sa_share::INST_BITS,
    parameter  int DEPTH     = 16,
    parameter  int CNT_BITS  = 32,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 s_valid,
    input  logic [INST_BITS-1:0] s_data,
    output logic                 s_ready,
    input  logic                 run,
    input  logic                 flush,
    input  logic                 cu_flag,
    output logic [INST_BITS-1:0] instruction,
    output logic                 empty,
    output logic                 full,
    output logic [CW-1:0]        count,
    output logic                 busy,
    output logic [CNT_BITS-1:0]  issued_cnt,
    output logic [CNT_BITS-1:0]  stall_cnt
);
    import sa_share::*;

    q_state_e             state_q, state_d;
    logic                 push, pop, clear, stall;
    logic [INST_BITS-1:0] head;

    inst_fifo_mem #(.W(INST_BITS), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (clear),
        .wdata_i (s_data),
        .rdata_o (head),
        .count_o (count),
        .empty_o (empty),
        .full_o  (full)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= Q_STOP;
        else          state_q <= state_d;
    end

    // Handshakes depend only on registered state, so a pop at full never
    // opens s_ready in the same cycle.
    always_comb begin
        state_d     = state_q;
        s_ready     = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        stall       = 1'b0;
        clear       = 1'b0;
        busy        = 1'b0;
        instruction = INST_BITS'(IDLE_INST);
        unique case (state_q)
            Q_STOP:  if (run)  state_d = Q_RUN;
            Q_RUN:   if (!run) state_d = Q_STOP;
            Q_FLUSH: state_d = Q_STOP;
            default: state_d = Q_STOP;
        endcase
        if (flush) state_d = Q_FLUSH;

        s_ready = !full && (state_q != Q_FLUSH);
        push    = s_valid && s_ready;
        clear   = (state_q == Q_FLUSH);
        busy    = (state_q == Q_RUN) && !empty;
        pop     = busy && cu_flag;
        stall   = (state_q == Q_RUN) && empty && cu_flag;
        if (busy) instruction = head;
    end

`ifdef INST_QUEUE_STATS_EN
    logic [CNT_BITS-1:0] issued_q, issued_d;
    logic [CNT_BITS-1:0] stall_q, stall_d;

    always_comb begin
        issued_d = issued_q;
        stall_d  = stall_q;
        if (clear) begin
            issued_d = '0;
            stall_d  = '0;
        end else begin
            if (pop   && !(&issued_q)) issued_d = issued_q + 1'b1;
            if (stall && !(&stall_q))  stall_d  = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign issued_cnt = issued_q;
    assign stall_cnt  = stall_q;
`else
    assign issued_cnt = '0;
    assign stall_cnt  = '0;
`endif

endmodule
